// File: rtl/seven_seg_reader_if.sv
// Bus bundle for the seven-segment reader: scanned display inputs in, assembled word out.
interface seven_seg_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;     // {A..G}, active low
    logic [DIGITS-1:0]   an_in;      // digit selects, active low
    logic [4*DIGITS-1:0] word_out;
    logic                word_valid;
    logic                word_err;
    logic [DIGITS-1:0]   dig_mask;

    modport master (
        output seg_in, an_in,
        input  word_out, word_valid, word_err, dig_mask
    );

    modport slave (
        input  seg_in, an_in,
        output word_out, word_valid, word_err, dig_mask
    );
endinterface

// File: rtl/seven_seg_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and
// assembles them into a DIGITS-wide word, flagging frames with invalid patterns.
module seven_seg_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    seven_seg_reader_if.slave   bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [6:0]              r_seg;
    logic [DIGITS-1:0]       r_an;
    logic [7:0]              r_cnt;
    logic                    r_done;    // this dwell already produced its strobe
    logic [DIGITS-1:0][3:0]  r_slot;
    logic [DIGITS-1:0]       r_mask;
    logic                    r_err;
    logic [4*DIGITS-1:0]     r_word;
    logic                    r_werr;
    logic                    r_valid;

    logic [DIGITS-1:0]       w_sel;
    logic                    w_one;
    logic                    w_cap;
    logic [4:0]              w_dec;
    logic                    w_full;

    // Segment pattern to {valid, nibble}; anything off-table is invalid.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: return {1'b1, 4'h0};
            7'b1001111: return {1'b1, 4'h1};
            7'b0010010: return {1'b1, 4'h2};
            7'b0000110: return {1'b1, 4'h3};
            7'b1001100: return {1'b1, 4'h4};
            7'b0100100: return {1'b1, 4'h5};
            7'b0100000: return {1'b1, 4'h6};
            7'b0001111: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0000100: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b1100000: return {1'b1, 4'hB};
            7'b0110001: return {1'b1, 4'hC};
            7'b1000010: return {1'b1, 4'hD};
            7'b0110000: return {1'b1, 4'hE};
            7'b0111000: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    // Only a single active anode identifies a digit; idle or overlapping selects are ignored.
    assign w_sel  = ~r_an;
    assign w_one  = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    assign w_cap  = (r_cnt == CNT_MAX) && !r_done && w_one;
    assign w_dec  = f_decode(r_seg);
    assign w_full = &r_mask;

    // Sample the bus and measure how long the sampled value has been steady.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg  <= '1;
            r_an   <= '1;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_seg <= bus.seg_in;
            r_an  <= bus.an_in;
            if ({bus.seg_in, bus.an_in} != {r_seg, r_an}) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 8'd1;
                if (r_cnt == CNT_MAX) r_done <= 1'b1;
            end
        end
    end

    // Capture digits into slots and publish the word once every digit has been seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot  <= '0;
            r_mask  <= '0;
            r_err   <= 1'b0;
            r_word  <= '0;
            r_werr  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_full;
            if (w_full) begin
                r_word <= r_slot;
                r_werr <= r_err;
            end
            r_mask <= (w_full ? '0 : r_mask) | (w_cap ? w_sel : '0);
            r_err  <= (w_full ? 1'b0 : r_err) | (w_cap & ~w_dec[4]);
            for (int i = 0; i < DIGITS; i++) begin
                if (w_cap && w_sel[i]) r_slot[i] <= w_dec[3:0];
            end
        end
    end

    assign bus.word_out   = r_word;
    assign bus.word_err   = r_werr;
    assign bus.word_valid = r_valid;
    assign bus.dig_mask   = r_mask;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench: dwell-level reference model predicts frames, monitors compare pulses.
module tb_seven_seg_reader;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seven_seg_reader_if #(.DIGITS(4)) bus ();
    seven_seg_reader_if #(.DIGITS(1)) bus1 ();

    seven_seg_reader #(.DIGITS(4), .STABLE_CYCLES(S)) dut  (.clk(clk), .reset(reset), .bus(bus));
    seven_seg_reader #(.DIGITS(1), .STABLE_CYCLES(S)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic [6:0] PAT [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int checks = 0;
    int errors = 0;

    logic [16:0] q0 [$];   // {word, err} for 4-digit instance
    logic [4:0]  q1 [$];   // {word, err} for 1-digit instance

    logic [3:0]  m_slot [4];
    logic [3:0]  m_mask = '0;
    logic        m_err  = 1'b0;
    logic [10:0] prev   = 11'h7FF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_dec(input logic [6:0] s, output logic [3:0] n);
        for (int k = 0; k < 16; k++) begin
            if (PAT[k] == s) begin
                n = 4'(k);
                return 1'b1;
            end
        end
        n = 4'h0;
        return 1'b0;
    endfunction

    function automatic int zero_idx(input logic [3:0] an);
        int cnt = 0;
        int idx = -1;
        for (int k = 0; k < 4; k++) if (!an[k]) begin cnt++; idx = k; end
        return (cnt == 1) ? idx : -1;
    endfunction

    // A steady dwell of at least S cycles on a single digit is one capture.
    task automatic model_cap(input logic [6:0] seg, input logic [3:0] an);
        int idx;
        logic [3:0] n;
        idx = zero_idx(an);
        if (idx >= 0) begin
            if (!ref_dec(seg, n)) m_err = 1'b1;
            m_slot[idx] = n;
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
                q0.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0], m_err});
                m_mask = '0;
                m_err  = 1'b0;
            end
        end
    endtask

    // Drive one dwell starting at a negedge; consecutive dwells always differ.
    task automatic dwell(input logic [6:0] seg_i, input logic [3:0] an, input int len);
        logic [6:0] seg;
        seg = seg_i;
        if ({seg, an} == prev) seg = seg ^ 7'h01;
        prev = {seg, an};
        bus.seg_in = seg;
        bus.an_in  = an;
        if (len >= S) model_cap(seg, an);
        repeat (len) @(negedge clk);
        if (len >= S + 2) chk("dig_mask", 32'(bus.dig_mask), 32'(m_mask));
    endtask

    // Scoreboard monitors: each word_valid pulse must match the oldest predicted frame.
    always @(posedge clk) begin
        #1;
        if (bus.word_valid) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL word4: unexpected pulse word=%h err=%b", bus.word_out, bus.word_err);
            end else begin
                logic [16:0] e;
                e = q0.pop_front();
                if ({bus.word_out, bus.word_err} !== e) begin
                    errors++;
                    $display("FAIL word4: got %h/%b expected %h/%b", bus.word_out, bus.word_err, e[16:1], e[0]);
                end
            end
        end
        if (bus1.word_valid) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL word1: unexpected pulse word=%h err=%b", bus1.word_out, bus1.word_err);
            end else begin
                logic [4:0] e;
                e = q1.pop_front();
                if ({bus1.word_out, bus1.word_err} !== e) begin
                    errors++;
                    $display("FAIL word1: got %h/%b expected %h/%b", bus1.word_out, bus1.word_err, e[4:1], e[0]);
                end
            end
        end
    end

    initial begin
        foreach (m_slot[k]) m_slot[k] = '0;
        bus.seg_in  = 7'h7F; bus.an_in  = 4'hF;
        bus1.seg_in = 7'h7F; bus1.an_in = 1'b1;
        #12;
        chk("rst_word",  32'(bus.word_out),   32'h0);
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_err",   32'(bus.word_err),   32'h0);
        chk("rst_mask",  32'(bus.dig_mask),   32'h0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-frame with two digits captured.
        dwell(PAT[1], 4'b1110, S + 2);
        dwell(PAT[2], 4'b1101, S + 2);
        chk("pre_rst_mask", 32'(bus.dig_mask), 32'h3);
        bus.seg_in = PAT[3]; bus.an_in = 4'b1011;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_mask",  32'(bus.dig_mask),   32'h0);
        chk("async_word",  32'(bus.word_out),   32'h0);
        chk("async_valid", 32'(bus.word_valid), 32'h0);
        m_mask = '0; m_err = 1'b0;
        bus.seg_in = 7'h7F; bus.an_in = 4'hF; prev = 11'h7FF;
        @(negedge clk); reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_mask", 32'(bus.dig_mask), 32'h0);

        // Ordered scan 3,0,2,1 with exact completion timing on the last digit.
        dwell(PAT[3], 4'b1110, 8);
        dwell(PAT[0], 4'b1101, 8);
        dwell(PAT[2], 4'b1011, 8);
        bus.seg_in = PAT[1]; bus.an_in = 4'b0111; prev = {PAT[1], 4'b0111};
        model_cap(PAT[1], 4'b0111);
        repeat (S) @(negedge clk);
        chk("lat_mask_pre", 32'(bus.dig_mask), 32'h7);
        @(negedge clk);
        chk("lat_mask_full", 32'(bus.dig_mask),   32'hF);
        chk("lat_valid_lo",  32'(bus.word_valid), 32'h0);
        @(negedge clk);
        chk("lat_valid_hi",  32'(bus.word_valid), 32'h1);
        chk("lat_word",      32'(bus.word_out),   32'h1203);
        chk("lat_mask_clr",  32'(bus.dig_mask),   32'h0);
        repeat (8 - S - 2) @(negedge clk);

        // Full table sweep on the single-digit instance.
        for (int k = 0; k < 16; k++) begin
            bus1.seg_in = PAT[k]; bus1.an_in = 1'b0;
            q1.push_back({4'(k), 1'b0});
            repeat (6) @(negedge clk);
        end
        bus1.seg_in = 7'h7F; bus1.an_in = 1'b1;

        // Blank digit flags the frame; next frame is clean.
        dwell(PAT[4], 4'b1110, 6);
        dwell(PAT[5], 4'b1101, 6);
        dwell(7'h7F,  4'b1011, 6);
        dwell(PAT[6], 4'b0111, 6);
        dwell(PAT[7], 4'b1110, 6);
        dwell(PAT[8], 4'b1101, 6);
        dwell(PAT[9], 4'b1011, 6);
        dwell(PAT[10], 4'b0111, 6);

        // Short glitches and a two-anode select must not capture.
        dwell(PAT[7], 4'b1110, 8);
        dwell(PAT[4], 4'b1101, S - 1);
        dwell(PAT[5], 4'b1011, S - 1);
        dwell(PAT[6], 4'b0101, 10);
        chk("glitch_mask", 32'(bus.dig_mask), 32'h1);
        dwell(PAT[1], 4'b1101, 6);
        dwell(PAT[2], 4'b1011, 6);
        dwell(PAT[3], 4'b0111, 6);

        // Overwrite of an already-captured digit before completion.
        dwell(PAT[5], 4'b1101, 6);
        dwell(PAT[0], 4'b1110, 6);
        dwell(PAT[9], 4'b1101, 6);
        dwell(PAT[12], 4'b1011, 6);
        dwell(PAT[15], 4'b0111, 6);

        // Randomized dwells: mixed valid/invalid patterns, selects and lengths.
        for (int t = 0; t < 300; t++) begin
            logic [6:0] seg;
            logic [3:0] an;
            seg = ($urandom % 4 == 0) ? 7'($urandom) : PAT[$urandom % 16];
            an  = ($urandom % 8 == 0) ? 4'($urandom) : ~(4'b0001 << ($urandom % 4));
            dwell(seg, an, int'($urandom_range(1, S + 4)));
        end
        dwell(7'h7F, 4'hF, 12);

        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: timeout reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
